// File: rtl/sd_cmd_seq.sv
// SD SPI-mode command sequencer: frames one 6-byte command as three 16-bit words and polls for R1.
// Define SD_CRC7_EN to generate a real CRC7 byte; otherwise fixed CMD0/CMD8 CRC bytes are used.
module sd_cmd_seq #(
    parameter int MAX_POLL = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  cmd_idx,
    input  logic [31:0] cmd_arg,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [7:0]  r1,
    output logic [15:0] spi_data,
    output logic        spi_en,
    input  logic        spi_done,
    input  logic [15:0] spi_dout
);

    localparam int PW = $clog2(MAX_POLL + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_WAIT, S_GAP, S_POLL, S_CHECK, S_FIN
    } state_t;

    state_t        state, state_nxt;
    logic [5:0]    idx_q, idx_nxt;
    logic [31:0]   arg_q, arg_nxt;
    logic [1:0]    word_cnt, word_nxt;
    logic [PW-1:0] poll_cnt, poll_nxt;
    logic          in_poll, in_poll_nxt;
    logic [15:0]   rx_q, rx_nxt;
    logic [7:0]    r1_q, r1_nxt;
    logic          to_q, to_nxt;
    logic [7:0]    crc_byte;
    logic [15:0]   frame_word;

`ifdef SD_CRC7_EN
    // CRC7, polynomial x^7+x^3+1, MSB first, zero init
    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    assign crc_byte = {crc7({2'b01, idx_q, arg_q}), 1'b1};
`else
    always_comb begin
        crc_byte = 8'h01;
        if (idx_q == 6'd0)      crc_byte = 8'h95;
        else if (idx_q == 6'd8) crc_byte = 8'h87;
    end
`endif

    always_comb begin
        case (word_cnt)
            2'd0:    frame_word = {2'b01, idx_q, arg_q[31:24]};
            2'd1:    frame_word = arg_q[23:8];
            default: frame_word = {arg_q[7:0], crc_byte};
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            idx_q    <= '0;
            arg_q    <= '0;
            word_cnt <= '0;
            poll_cnt <= '0;
            in_poll  <= 1'b0;
            rx_q     <= 16'hFFFF;
            r1_q     <= 8'hFF;
            to_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx_q    <= idx_nxt;
            arg_q    <= arg_nxt;
            word_cnt <= word_nxt;
            poll_cnt <= poll_nxt;
            in_poll  <= in_poll_nxt;
            rx_q     <= rx_nxt;
            r1_q     <= r1_nxt;
            to_q     <= to_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx_q;
        arg_nxt     = arg_q;
        word_nxt    = word_cnt;
        poll_nxt    = poll_cnt;
        in_poll_nxt = in_poll;
        rx_nxt      = rx_q;
        r1_nxt      = r1_q;
        to_nxt      = to_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    idx_nxt     = cmd_idx;
                    arg_nxt     = cmd_arg;
                    to_nxt      = 1'b0;
                    word_nxt    = '0;
                    poll_nxt    = '0;
                    in_poll_nxt = 1'b0;
                    state_nxt   = S_SEND;
                end
            end
            S_SEND, S_POLL: state_nxt = S_WAIT;
            S_WAIT: begin
                if (spi_done) begin
                    rx_nxt    = spi_dout;
                    state_nxt = in_poll ? S_CHECK : S_GAP;
                end
            end
            S_GAP: begin
                if (word_cnt == 2'd2) begin
                    in_poll_nxt = 1'b1;
                    state_nxt   = S_POLL;
                end else begin
                    word_nxt  = word_cnt + 2'd1;
                    state_nxt = S_SEND;
                end
            end
            S_CHECK: begin
                if (!rx_q[15]) begin
                    r1_nxt    = rx_q[15:8];
                    state_nxt = S_FIN;
                end else if (!rx_q[7]) begin
                    r1_nxt    = rx_q[7:0];
                    state_nxt = S_FIN;
                end else begin
                    // CHECK doubles as the one-cycle EN-low gap before the next poll word
                    poll_nxt = poll_cnt + PW'(1);
                    if (poll_nxt == PW'(MAX_POLL)) begin
                        to_nxt    = 1'b1;
                        r1_nxt    = 8'hFF;
                        state_nxt = S_FIN;
                    end else begin
                        state_nxt = S_POLL;
                    end
                end
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy     = (state != S_IDLE);
    assign done     = (state == S_FIN);
    assign timeout  = to_q;
    assign r1       = r1_q;
    assign spi_en   = (state == S_SEND) || (state == S_POLL) || (state == S_WAIT);
    assign spi_data = (spi_en && !in_poll) ? frame_word : 16'hFFFF;

endmodule
